jk_bank_sequencer: RTL and testbench

Command sequencer and two-port arbiter for a bank of WIDTH JK flip-flops. Two requesters submit masked bank operations (hold/clear/set/toggle) over valid/ready handshakes. The block grants one request at a time round-robin, drives the bank's J/K vectors for exactly one clock, and waits for the bank to settle. It then returns the bank's new Q state to the granted requester. It sits between the control logic and the flip-flop bank and is the bank's only J/K driver.

---
 rtl/jk_bank_sequencer_if.sv | 13 +
 rtl/jk_bank_sequencer.sv | 101 ++++++++++
 tb/tb_jk_bank_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_sequencer_if.sv
// Valid/ready command channel from one requester to the JK bank sequencer.
// The requester drives op/mask under valid; the sequencer answers with ready.
interface jk_bank_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [1:0]       op;
  logic [WIDTH-1:0] mask;
  logic             ready;

  modport master (output valid, op, mask, input ready);
  modport slave  (input valid, op, mask, output ready);
endinterface

// File: rtl/jk_bank_sequencer.sv
// Round-robin command sequencer for a bank of JK flip-flops: accept, apply J/K
// for one cycle, let the bank settle, then hand the new Q back to the requester.
module jk_bank_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic              Clk,
  input  logic              rst,
  jk_bank_sequencer_if.slave req0,
  jk_bank_sequencer_if.slave req1,
  output logic [WIDTH-1:0]  J,
  output logic [WIDTH-1:0]  K,
  input  logic [WIDTH-1:0]  Q_in,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [WIDTH-1:0]  resp_q,
  input  logic              resp_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_RESP
  } state_t;

  state_t           state, state_next;
  logic             last_grant;
  logic             id_q;
  logic             grant_id;
  logic             accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_mask;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    req0.ready = 1'b0;
    req1.ready = 1'b0;
    // On a tie the requester that did not win last time goes next.
    if (req0.valid && req1.valid) grant_id = ~last_grant;
    else                          grant_id = req1.valid;

    unique case (state)
      S_IDLE: begin
        if (rst && (req0.valid || req1.valid)) begin
          accept     = 1'b1;
          state_next = S_APPLY;
          if (grant_id) req1.ready = 1'b1;
          else          req0.ready = 1'b1;
        end
      end
      S_APPLY:  state_next = S_SETTLE;
      S_SETTLE: state_next = S_RESP;
      S_RESP:   if (resp_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  assign sel_op   = grant_id ? req1.op   : req0.op;
  assign sel_mask = grant_id ? req1.mask : req0.mask;

  // J/K are loaded on the accept edge and cleared on the next one, so they are
  // nonzero only for the APPLY cycle. Op bit 1 means J, op bit 0 means K.
  always_ff @(posedge Clk) begin
    if (!rst) begin
      J          <= '0;
      K          <= '0;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      resp_q     <= '0;
      resp_id    <= 1'b0;
    end else begin
      J <= '0;
      K <= '0;
      if (accept) begin
        J          <= sel_mask & {WIDTH{sel_op[1]}};
        K          <= sel_mask & {WIDTH{sel_op[0]}};
        id_q       <= grant_id;
        last_grant <= grant_id;
      end
      if (state == S_SETTLE) begin
        resp_q  <= Q_in;
        resp_id <= id_q;
      end
    end
  end

  assign resp_valid = (state == S_RESP);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: a behavioural JK bank plus a bank-state model
// driven by op semantics, with directed and randomized commands.
module tb_jk_bank_sequencer;
  localparam int W = 8;

  logic         Clk;
  logic         rst;
  logic [W-1:0] J, K, Q_in;
  logic         resp_valid, resp_id, resp_ready, busy;
  logic [W-1:0] resp_q;
  logic [W-1:0] q_bank = '0;

  int checks   = 0;
  int failures = 0;

  // Reference state: expected bank contents and last granted requester.
  logic [W-1:0] exp_q = '0;
  bit           last_m = 1'b1;

  jk_bank_sequencer_if #(.WIDTH(W)) r0 ();
  jk_bank_sequencer_if #(.WIDTH(W)) r1 ();

  jk_bank_sequencer #(.WIDTH(W)) dut (
    .Clk        (Clk),
    .rst        (rst),
    .req0       (r0),
    .req1       (r1),
    .J          (J),
    .K          (K),
    .Q_in       (Q_in),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_q     (resp_q),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Rising-edge JK bank: Q+ = J&~Q | ~K&Q
  always @(posedge Clk) q_bank <= (J & ~q_bank) | (~K & q_bank);
  assign Q_in = q_bank;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_j(input logic [1:0] op, input logic [W-1:0] m);
    return (op == 2'b10 || op == 2'b11) ? m : '0;
  endfunction

  function automatic logic [W-1:0] exp_k(input logic [1:0] op, input logic [W-1:0] m);
    return (op == 2'b01 || op == 2'b11) ? m : '0;
  endfunction

  function automatic logic [W-1:0] apply_op(input logic [W-1:0] q, input logic [1:0] op,
                                            input logic [W-1:0] m);
    case (op)
      2'b01:   return q & ~m;
      2'b10:   return q | m;
      2'b11:   return q ^ m;
      default: return q;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    rst = 1'b0;
    @(negedge Clk);
    rst    = 1'b1;
    last_m = 1'b1;
  endtask

  // One command from a single requester; stall = extra RESP cycles with resp_ready low.
  task automatic run_cmd(input bit id, input logic [1:0] op, input logic [W-1:0] mask,
                         input int stall);
    @(negedge Clk);
    if (id) begin r1.valid = 1'b1; r1.op = op; r1.mask = mask; end
    else    begin r0.valid = 1'b1; r0.op = op; r0.mask = mask; end
    #1;
    check("ready_winner", id ? r1.ready : r0.ready, 1);
    check("ready_other",  id ? r0.ready : r1.ready, 0);
    check("busy_idle", busy, 0);
    exp_q  = apply_op(exp_q, op, mask);
    last_m = id;
    @(negedge Clk);
    r0.valid = 1'b0;
    r1.valid = 1'b0;
    #1;
    check("apply_j", J, exp_j(op, mask));
    check("apply_k", K, exp_k(op, mask));
    check("busy_apply", busy, 1);
    @(negedge Clk);
    if (stall > 0) resp_ready = 1'b0;
    #1;
    check("settle_jk", {J, K}, 0);
    check("settle_rv", resp_valid, 0);
    @(negedge Clk);
    #1;
    check("resp_valid", resp_valid, 1);
    check("resp_q", resp_q, exp_q);
    check("resp_id", resp_id, id);
    for (int i = 0; i < stall; i++) begin
      @(negedge Clk);
      r0.valid = 1'b1;
      r1.valid = 1'b1;
      #1;
      check("stall_valid", resp_valid, 1);
      check("stall_q", resp_q, exp_q);
      check("stall_id", resp_id, id);
      check("stall_busy", busy, 1);
      check("stall_ready", {r0.ready, r1.ready}, 0);
      check("stall_jk", {J, K}, 0);
    end
    resp_ready = 1'b1;
    r0.valid   = 1'b0;
    r1.valid   = 1'b0;
    @(negedge Clk);
    #1;
    check("back_idle_rv", resp_valid, 0);
    check("back_idle_busy", busy, 0);
  endtask

  initial begin
    bit           w;
    logic [1:0]   wop;
    logic [W-1:0] wmask;

    rst        = 1'b0;
    resp_ready = 1'b1;
    r0.valid = 1'b0; r0.op = 2'b00; r0.mask = '0;
    r1.valid = 1'b0; r1.op = 2'b00; r1.mask = '0;

    // Reset state, including ready suppressed while rst is low.
    repeat (2) @(negedge Clk);
    r0.valid = 1'b1;
    r1.valid = 1'b1;
    #1;
    check("rst_jk", {J, K}, 0);
    check("rst_resp", {resp_valid, resp_id, resp_q}, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", {r0.ready, r1.ready}, 0);
    r0.valid = 1'b0;
    r1.valid = 1'b0;
    @(negedge Clk);
    rst = 1'b1;

    // Directed sequence: set low nibble, toggle all, clear high nibble.
    run_cmd(1'b0, 2'b10, 8'h0F, 0);
    run_cmd(1'b1, 2'b11, 8'hFF, 0);
    check("toggle_result", exp_q, 8'hF0);
    run_cmd(1'b0, 2'b01, 8'hF0, 0);

    // Both valid continuously: alternating grants, accepts 4 cycles apart.
    do_reset();
    @(negedge Clk);
    r0.op = 2'($urandom_range(0, 3)); r0.mask = W'($urandom);
    r1.op = 2'($urandom_range(0, 3)); r1.mask = W'($urandom);
    r0.valid = 1'b1;
    r1.valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      w = ~last_m;
      check("tie_grant0", r0.ready, !w);
      check("tie_grant1", r1.ready, w);
      check("tie_expect_alt", w, k % 2);
      wop    = w ? r1.op   : r0.op;
      wmask  = w ? r1.mask : r0.mask;
      exp_q  = apply_op(exp_q, wop, wmask);
      last_m = w;
      @(negedge Clk);
      if (w) begin r1.op = 2'($urandom_range(0, 3)); r1.mask = W'($urandom); end
      else   begin r0.op = 2'($urandom_range(0, 3)); r0.mask = W'($urandom); end
      #1;
      check("tie_apply_j", J, exp_j(wop, wmask));
      check("tie_apply_k", K, exp_k(wop, wmask));
      check("tie_busy_ready", {busy, r0.ready, r1.ready}, 3'b100);
      @(negedge Clk);
      #1;
      check("tie_settle_ready", {busy, r0.ready, r1.ready}, 3'b100);
      @(negedge Clk);
      #1;
      check("tie_resp_ready", {busy, r0.ready, r1.ready}, 3'b100);
      check("tie_resp_id", resp_id, w);
      check("tie_resp_q", resp_q, exp_q);
      @(negedge Clk);
    end
    r0.valid = 1'b0;
    r1.valid = 1'b0;

    // Response back-pressure for 5 cycles.
    run_cmd(1'b1, 2'b11, 8'h3C, 5);

    // Hold with full mask, and set with empty mask: Q unchanged.
    run_cmd(1'b0, 2'b00, 8'hFF, 0);
    run_cmd(1'b1, 2'b10, 8'h00, 0);

    // Randomized commands with random response stalls.
    repeat (10) begin
      run_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), W'($urandom),
              int'($urandom_range(0, 3)));
    end

    // Reset during APPLY: in-flight command dropped, tie then goes to req0.
    @(negedge Clk);
    r1.valid = 1'b1; r1.op = 2'b11; r1.mask = 8'hFF;
    @(negedge Clk);
    r1.valid = 1'b0;
    #1;
    check("pre_rst_apply_j", J, 8'hFF);
    rst   = 1'b0;
    exp_q = exp_q ^ 8'hFF;
    @(negedge Clk);
    r0.valid = 1'b1; r0.op = 2'b00; r0.mask = 8'h00;
    r1.valid = 1'b1; r1.op = 2'b00; r1.mask = 8'h00;
    #1;
    check("mid_rst_jk", {J, K}, 0);
    check("mid_rst_rv_busy", {resp_valid, busy}, 0);
    check("mid_rst_ready", {r0.ready, r1.ready}, 0);
    @(negedge Clk);
    rst = 1'b1;
    #1;
    check("post_rst_tie0", r0.ready, 1);
    check("post_rst_tie1", r1.ready, 0);
    @(negedge Clk);
    r0.valid = 1'b0;
    r1.valid = 1'b0;
    #1;
    check("post_rst_apply", {J, K}, 0);
    repeat (2) @(negedge Clk);
    #1;
    check("post_rst_resp_v", resp_valid, 1);
    check("post_rst_resp_id", resp_id, 0);
    check("post_rst_resp_q", resp_q, exp_q);
    @(negedge Clk);
    #1;
    check("post_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
